// File: rtl/upd7801_bus_pkg.sv
// rtl/upd7801_bus_pkg.sv - shared types and constants for the uPD7801 bus target
package upd7801_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [7:0] DB_IDLE = 8'hFF;
  localparam int TO_W = 8;

endpackage

// File: rtl/upd7801_bus_target.sv
// rtl/upd7801_bus_target.sv - uPD7801 bus responder bridging CPU strobes to a variable-latency memory port
module upd7801_bus_target
  import upd7801_bus_pkg::*;
#(
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CP1_POSEDGE,
  input  logic [15:0] A,
  input  logic        A_OE,
  input  logic        RDB,
  input  logic        WRB,
  input  logic [7:0]  DB_O,
  output logic [7:0]  DB_I,
  output logic        WAITB,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        ERR
);

  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] WAIT_LOAD = TO_W'(MIN_WAIT);
  localparam logic [TO_W-1:0] TO_MAX    = '1;

  state_t          state, next_state;
  logic            strobe;
  logic            aborted;
  logic            abort_now;
  logic            accept;
  logic            timeout_hit;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_inc;
  logic [TO_W-1:0] wait_cnt;
  logic            mem_req_d;
  logic            waitb_d;

  // Both strobes low is illegal on the bus; it falls through as a write.
  assign strobe      = A_OE & ~(RDB & WRB);
  assign abort_now   = aborted | ~strobe;
  assign to_cnt_inc  = (to_cnt == TO_MAX) ? TO_MAX : to_cnt + TO_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_inc == TO_LIMIT);
  assign accept      = (state == IDLE) && (next_state == REQ);

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (CP1_POSEDGE && strobe) next_state = REQ;
      REQ: begin
        // A CPU that walked away still lets memory finish, but never sees WAITB.
        if (MEM_ACK)          next_state = abort_now ? IDLE : HOLD;
        else if (timeout_hit) next_state = abort_now ? IDLE : DONE;
      end
      HOLD: begin
        if (abort_now)                          next_state = IDLE;
        else if (CP1_POSEDGE && wait_cnt == '0) next_state = DONE;
      end
      DONE: if (!strobe) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d = (next_state == REQ);
    waitb_d   = (next_state == DONE);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      MEM_REQ <= 1'b0;
      WAITB   <= 1'b0;
    end else begin
      MEM_REQ <= mem_req_d;
      WAITB   <= waitb_d;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      DB_I      <= DB_IDLE;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      ERR       <= 1'b0;
      to_cnt    <= '0;
      wait_cnt  <= '0;
      aborted   <= 1'b0;
    end else begin
      if (accept) begin
        MEM_ADDR  <= A;
        MEM_WDATA <= DB_O;
        MEM_WE    <= ~WRB;
        DB_I      <= DB_IDLE;
        to_cnt    <= '0;
        aborted   <= 1'b0;
      end else if ((state == REQ || state == HOLD) && !strobe) begin
        aborted <= 1'b1;
      end

      if (state == REQ) begin
        to_cnt <= to_cnt_inc;
        if (MEM_ACK) begin
          if (!MEM_WE) DB_I <= MEM_RDATA;
          wait_cnt <= WAIT_LOAD;
        end else if (timeout_hit) begin
          ERR  <= 1'b1;
          DB_I <= DB_IDLE;
        end
      end

      if (state == HOLD && CP1_POSEDGE && wait_cnt != '0)
        wait_cnt <= wait_cnt - TO_W'(1);
    end
  end

endmodule

// File: tb/tb_upd7801_bus_target.sv
// tb/tb_upd7801_bus_target.sv - self-checking bench for upd7801_bus_target
module tb_upd7801_bus_target;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          ack_dly;
    logic [7:0]  exp_db;
    logic        exp_we;
  } vec_t;

  typedef struct {
    logic [7:0]  db;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        err;
  } exp_t;

  logic        CLK = 0;
  logic        RES = 1;
  logic        CP1 = 0;
  logic [15:0] A = '0;
  logic        A_OE = 0;
  logic [7:0]  DB_O = '0;
  logic        rdb0 = 1, wrb0 = 1, ack0 = 0;
  logic        rdb2 = 1, wrb2 = 1, ack2 = 0;
  logic [7:0]  rdata0 = 8'hEE, rdata2 = 8'hEE;

  logic [7:0]  db0, db2, wdata0, wdata2;
  logic [15:0] addr0, addr2;
  logic        waitb0, waitb2, req0, req2, we0, we2, err0, err2;

  int checks = 0;
  int failures = 0;
  int cp1_count = 0;
  logic cp1_last = 0;
  exp_t sb[$];
  vec_t vecs[5];

  upd7801_bus_target #(.MIN_WAIT(0), .TIMEOUT(16)) dut0 (
    .CLK(CLK), .RES(RES), .CP1_POSEDGE(CP1), .A(A), .A_OE(A_OE),
    .RDB(rdb0), .WRB(wrb0), .DB_O(DB_O), .DB_I(db0), .WAITB(waitb0),
    .MEM_REQ(req0), .MEM_WE(we0), .MEM_ADDR(addr0), .MEM_WDATA(wdata0),
    .MEM_RDATA(rdata0), .MEM_ACK(ack0), .ERR(err0)
  );

  upd7801_bus_target #(.MIN_WAIT(2), .TIMEOUT(255)) dut2 (
    .CLK(CLK), .RES(RES), .CP1_POSEDGE(CP1), .A(A), .A_OE(A_OE),
    .RDB(rdb2), .WRB(wrb2), .DB_O(DB_O), .DB_I(db2), .WAITB(waitb2),
    .MEM_REQ(req2), .MEM_WE(we2), .MEM_ADDR(addr2), .MEM_WDATA(wdata2),
    .MEM_RDATA(rdata2), .MEM_ACK(ack2), .ERR(err2)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cp1_last <= CP1;
    if (CP1) cp1_count <= cp1_count + 1;
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge CLK);
      ph = (ph + 1) % 4;
      CP1 = (ph == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_access(input vec_t v, input logic exp_err);
    exp_t e, got;
    int n;
    e.db = v.exp_db; e.addr = v.addr; e.we = v.exp_we; e.wdata = v.wdata; e.err = exp_err;
    sb.push_back(e);
    @(negedge CLK);
    A = v.addr; DB_O = v.wdata; A_OE = 1; rdb0 = v.wr; wrb0 = ~v.wr;
    n = 0;
    while (!req0 && n < 40) begin @(negedge CLK); n++; end
    check("req_seen", 32'(req0), 32'(1));
    for (int i = 0; i < v.ack_dly; i++) @(negedge CLK);
    ack0 = 1; rdata0 = v.rdata;
    @(negedge CLK);
    ack0 = 0; rdata0 = 8'hEE;
    n = 0;
    while (!waitb0 && n < 40) begin @(negedge CLK); n++; end
    check("waitb_rise", 32'(waitb0), 32'(1));
    check("waitb_on_cp1", 32'(cp1_last), 32'(1));
    got = sb.pop_front();
    check("db_i", 32'(db0), 32'(got.db));
    check("mem_addr", 32'(addr0), 32'(got.addr));
    check("mem_we", 32'(we0), 32'(got.we));
    check("mem_wdata", 32'(wdata0), 32'(got.wdata));
    check("err", 32'(err0), 32'(got.err));
    rdb0 = 1; wrb0 = 1; A_OE = 0;
    @(negedge CLK);
    check("waitb_fall", 32'(waitb0), 32'(0));
  endtask

  initial begin
    int n, c0;
    vecs[0] = '{wr:1'b0, addr:16'h1234, wdata:8'h00, rdata:8'h5A, ack_dly:3, exp_db:8'h5A, exp_we:1'b0};
    vecs[1] = '{wr:1'b1, addr:16'h8123, wdata:8'hC3, rdata:8'h99, ack_dly:1, exp_db:8'hFF, exp_we:1'b1};
    vecs[2] = '{wr:1'b0, addr:16'h00FF, wdata:8'h11, rdata:8'hA5, ack_dly:0, exp_db:8'hA5, exp_we:1'b0};
    vecs[3] = '{wr:1'b0, addr:16'hFFFF, wdata:8'h22, rdata:8'h00, ack_dly:7, exp_db:8'h00, exp_we:1'b0};
    vecs[4] = '{wr:1'b1, addr:16'h0000, wdata:8'h7E, rdata:8'h33, ack_dly:2, exp_db:8'hFF, exp_we:1'b1};

    repeat (3) @(negedge CLK);
    check("rst_db_i", 32'(db0), 32'h0FF);
    check("rst_waitb", 32'(waitb0), 32'(0));
    check("rst_req", 32'(req0), 32'(0));
    check("rst_we", 32'(we0), 32'(0));
    check("rst_addr", 32'(addr0), 32'(0));
    check("rst_wdata", 32'(wdata0), 32'(0));
    check("rst_err", 32'(err0), 32'(0));
    check("rst2_db_i", 32'(db2), 32'h0FF);
    RES = 0;
    repeat (2) @(negedge CLK);
    check("idle_waitb", 32'(waitb0), 32'(0));

    for (int i = 0; i < 5; i++) run_access(vecs[i], 1'b0);

    // timeout: no ACK, TIMEOUT=16
    @(negedge CLK);
    A = 16'h5555; A_OE = 1; rdb0 = 0;
    n = 0;
    while (!req0 && n < 40) begin @(negedge CLK); n++; end
    check("to_req_seen", 32'(req0), 32'(1));
    n = 0;
    while (req0 && n < 40) begin n++; @(negedge CLK); end
    check("to_req_len", 32'(n), 32'd16);
    check("to_waitb", 32'(waitb0), 32'(1));
    check("to_err", 32'(err0), 32'(1));
    check("to_db_i", 32'(db0), 32'h0FF);
    rdb0 = 1; A_OE = 0;
    @(negedge CLK);
    check("to_waitb_fall", 32'(waitb0), 32'(0));
    run_access(vecs[0], 1'b1);

    // CPU abort while in REQ
    @(negedge CLK);
    A = 16'h2222; A_OE = 1; rdb0 = 0;
    n = 0;
    while (!req0 && n < 40) begin @(negedge CLK); n++; end
    check("ab_req_seen", 32'(req0), 32'(1));
    rdb0 = 1; A_OE = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("ab_req_held", 32'(req0), 32'(1));
      check("ab_waitb_low", 32'(waitb0), 32'(0));
    end
    ack0 = 1; rdata0 = 8'h44;
    @(negedge CLK);
    ack0 = 0; rdata0 = 8'hEE;
    check("ab_req_drop", 32'(req0), 32'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("ab_waitb_never", 32'(waitb0), 32'(0));
    end
    run_access(vecs[2], 1'b1);

    // MIN_WAIT=2 with immediate ACK
    @(negedge CLK);
    A = 16'h4242; A_OE = 1; rdb2 = 0;
    n = 0;
    while (!req2 && n < 40) begin @(negedge CLK); n++; end
    check("mw_req_seen", 32'(req2), 32'(1));
    c0 = cp1_count;
    ack2 = 1; rdata2 = 8'h3C;
    @(negedge CLK);
    ack2 = 0; rdata2 = 8'hEE;
    n = 0;
    while (!waitb2 && n < 40) begin @(negedge CLK); n++; end
    check("mw_waitb_rise", 32'(waitb2), 32'(1));
    check("mw_cp1_periods", 32'(cp1_count - c0), 32'd3);
    check("mw_db_i", 32'(db2), 32'h03C);
    rdb2 = 1; A_OE = 0;
    @(negedge CLK);
    check("mw_waitb_fall", 32'(waitb2), 32'(0));

    // RES while in HOLD
    @(negedge CLK);
    A = 16'h6060; A_OE = 1; rdb2 = 0;
    n = 0;
    while (!req2 && n < 40) begin @(negedge CLK); n++; end
    ack2 = 1; rdata2 = 8'h81;
    @(negedge CLK);
    ack2 = 0; rdata2 = 8'hEE;
    check("hold_addr", 32'(addr2), 32'h6060);
    #2 RES = 1;
    #1;
    check("hr_db_i", 32'(db2), 32'h0FF);
    check("hr_waitb", 32'(waitb2), 32'(0));
    check("hr_req", 32'(req2), 32'(0));
    check("hr_addr", 32'(addr2), 32'(0));
    check("hr_err0", 32'(err0), 32'(0));
    rdb2 = 1; A_OE = 0;
    @(negedge CLK);
    RES = 0;
    ack2 = 1; rdata2 = 8'h77;
    @(negedge CLK);
    ack2 = 0; rdata2 = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("stray_ack_waitb", 32'(waitb2), 32'(0));
    end
    check("stray_ack_db", 32'(db2), 32'h0FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/upd7801_bus_target.md
# upd7801_bus_target

Bus responder for the uPD7801 external memory interface. It answers CPU read/write strobes on A/DB, holds the CPU with WAITB until a backing memory port (SDRAM/BRAM arbiter, variable latency) acknowledges, and returns read data on DB_I. It sits between the upd7801 pins and the system memory arbiter in place of the ad-hoc ready logic used for cartridge/VRAM in simulation.

## Interface
Parameters:
- MIN_WAIT, 0, extra CP1 periods WAITB stays low after ACK (models slow devices)
- TIMEOUT, 255, CLK cycles without MEM_ACK before the access is aborted (8-bit counter; 0 disables)

Ports:
- CLK  in  1  system clock (only clock)
- RES  in  1  asynchronous, active-high reset
- CP1_POSEDGE  in  1  CPU phase-1 rising-edge enable
- A  in  16  CPU address
- A_OE  in  1  address valid
- RDB  in  1  CPU read strobe, active low
- WRB  in  1  CPU write strobe, active low
- DB_O  in  8  CPU write data
- DB_I  out  8  read data to CPU
- WAITB  out  1  ready to CPU; 1 = current access complete
- MEM_REQ  out  1  request to memory, level, held until ACK
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  16  latched A
- MEM_WDATA  out  8  latched DB_O
- MEM_RDATA  in  8  read data, valid with MEM_ACK
- MEM_ACK  in  1  single-cycle completion pulse
- ERR  out  1  sticky timeout flag, cleared only by RES

## Operation
- Strobe active = A_OE & ~(RDB & WRB). RDB and WRB both low is illegal; treated as write.
- States: IDLE, REQ, HOLD, DONE, ABORT.
- IDLE: on CP1_POSEDGE with strobe active, latch A, DB_O, write flag; set MEM_REQ; -> REQ. Strobe appearing between CP1 edges waits for the next CP1_POSEDGE.
- REQ: MEM_REQ=1, timeout counter increments each CLK. MEM_ACK: capture MEM_RDATA (reads only), drop MEM_REQ, load wait counter with MIN_WAIT; -> HOLD. Counter reaching TIMEOUT without ACK: drop MEM_REQ, set ERR, DB_I latch <= 8'hFF; -> DONE. ACK and timeout same cycle: ACK wins.
- HOLD: decrement wait counter on each CP1_POSEDGE; at 0 (immediately if MIN_WAIT=0) on next CP1_POSEDGE -> DONE.
- DONE: WAITB=1, DB_I = latched data. When strobe inactive (sampled every CLK) -> IDLE, WAITB=0 same cycle.
- Strobe released while in REQ/HOLD (CPU abort): request still completes to memory (never retract MEM_REQ before ACK); then return to IDLE without asserting WAITB.
- New access is never accepted until IDLE; back-to-back strobes with no gap require one CLK of inactive strobe.
- ABORT is reserved encoding; unreachable, decodes to IDLE.

## Timing
- Reset values: DB_I=8'hFF, WAITB=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, ERR=0, state IDLE.
- All outputs registered.
- MEM_REQ rises 1 CLK after the accepting CP1_POSEDGE.
- WAITB rises on the first CP1_POSEDGE after ACK + MIN_WAIT CP1 periods; minimum latency strobe-to-WAITB = 1 CP1 period + memory latency rounded up to CP1.
- DB_I valid no later than the CLK edge that raises WAITB; stable until WAITB falls.
- Timeout counter saturates, resets on entering REQ.
- RES mid-access: immediate return to reset values; outstanding MEM_ACK after reset ignored in IDLE.

## Structure
- Package upd7801_bus_pkg: state enum (IDLE, REQ, HOLD, DONE, ABORT), DB_IDLE = 8'hFF constant, timeout counter width.
- Single module, no sub-module; wait and timeout counters inline.

## Test plan
- Read, ACK 3 CLK after REQ, MEM_RDATA=8'h5A, MIN_WAIT=0 -> MEM_ADDR=A, MEM_WE=0, DB_I=8'h5A with WAITB=1 on next CP1_POSEDGE; WAITB=0 one CLK after RDB rises.
- Write A=16'h8123, DB_O=8'hC3 -> MEM_WE=1, MEM_ADDR=16'h8123, MEM_WDATA=8'hC3; WAITB after ACK; DB_I stays 8'hFF.
- MIN_WAIT=2, immediate ACK -> WAITB rises exactly 3 CP1 periods after the accepting edge.
- No ACK, TIMEOUT=16 -> MEM_REQ drops after 16 CLK, ERR=1, DB_I=8'hFF, WAITB=1; ERR persists across later accesses until RES.
- Strobe released in REQ -> MEM_REQ held until ACK, WAITB never rises, state returns IDLE; next read completes normally.
- RES asserted in HOLD -> all outputs at reset values asynchronously; stray ACK afterwards causes no WAITB.
